change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Refund/change-issuing end of the payment path: takes an excess amount, such as a stored excess from the payment collector, and pays it out as discrete currency notes.
- Uses greedy largest-note-first selection against per-denomination inventory counters.
- Presents one note at a time on a valid/ack handshake to the note-ejector mechanism.
- Reports completion, or a shortfall when inventory cannot cover the amount.

Parameters:
- AMT_W, 16, width of amounts.
- CNT_W, 8, width of each per-denomination inventory counter.
- INV_INIT, 10, count loaded into every denomination on reset and on restock.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- refund_req  in  1  single-cycle start pulse; sampled only in IDLE.
- refund_amt  in  AMT_W  amount to refund; captured with refund_req.
- restock  in  1  pulse; reloads all inventory counters to INV_INIT; honoured only in IDLE.
- note_ack  in  1  ejector has taken the presented note.
- note_valid  out  1  a note is being presented.
- note_code  out  4  denomination code of the presented note; 0 = none.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: refund fully paid.
- short  out  1  one-cycle pulse: refund aborted for lack of notes.
- remaining  out  AMT_W  amount still owed.
- dispensed  out  AMT_W  amount paid out for the current or most recent refund.

Behaviour:
- Denomination codes and values:
  - 1=1, 2=2, 3=5, 4=10, 5=20, 6=50, 7=100, 8=200, 9=500.
  - Codes 0 and 10-15 are never emitted.
- Reset (rst low, asynchronous):
  - state=IDLE.
  - note_valid=0, note_code=0, busy=0, done=0, short=0, remaining=0, dispensed=0.
  - All nine inventory counters = INV_INIT.
- IDLE:
  - On refund_req: remaining<=refund_amt, dispensed<=0.
  - Next state is DONE if refund_amt==0, else SELECT.
  - restock in IDLE reloads the counters. If it coincides with refund_req, both take effect; SELECT sees the reloaded counts.
- SELECT (exactly 1 cycle):
  - Pick the highest code whose value <= remaining and whose counter > 0.
  - If a code is found: register it into note_code and go to PRESENT.
  - Else if remaining==0: go to DONE.
  - Else: go to SHORT.
- PRESENT:
  - note_valid=1; note_code is held stable until the cycle note_ack is sampled high.
  - On ack, in the same edge:
    - remaining -= value.
    - dispensed += value.
    - The counter for that code decrements.
    - note_valid drops, note_code <= 0, and the next state is SELECT.
  - note_ack outside PRESENT is ignored.
- DONE: done=1 for one cycle, then IDLE.
- SHORT: short=1 for one cycle; remaining and dispensed keep the unpaid and paid values; then IDLE.
- remaining and dispensed hold their values in IDLE until the next refund_req.
- Latency:
  - refund_req sampled at edge N: SELECT during N+1, note_valid high from N+2.
  - Each later note costs 1 cycle of SELECT plus the ack wait. With ack tied high, a note issues every 2 cycles.
- refund_req and restock are ignored while busy.
- Arithmetic:
  - No overflow is possible: dispensed + remaining == refund_amt always holds during and after a refund.
  - Counters never underflow, because a code with count 0 is never selected.
- Reset mid-PRESENT: note_valid drops immediately and the refund is discarded. Inventory returns to INV_INIT, so the note in flight is not accounted for.

Decomposition:
- Shared package (payment_pkg) holds:
  - The state enum.
  - Denomination code constants.
  - A function mapping code to value.
  - NUM_DENOM=9.
- One sub-module, note_selector: combinational greedy pick.
  - Inputs: remaining, inventory-nonzero vector.
  - Outputs: code and found.
- The FSM, inventory counters and accumulators stay in change_dispenser.

Test Plan:
1. Reset, INV_INIT=10, refund_amt=388, note_ack tied high.
   - Expected: codes 8,7,6,5,4,3,2,1 in order; done pulse; dispensed=388, remaining=0; short never asserted.
2. INV_INIT=2, refund 1200.
   - Expected: codes 9,9,8; done.
   - Then refund 1200 again: 8, then 7,7,6,6,5,5,4,4,3,3,2,2,1,1; short pulse; dispensed=576, remaining=624.
3. refund_amt=0.
   - Expected: done pulses 2 cycles after refund_req; no note_valid; dispensed=0.
4. refund 7 with note_ack delayed 3 cycles per note.
   - Expected: note_code stable at 3 while unacked, then 2; done; dispensed=7.
   - A second refund_req pulsed while busy is ignored.
5. Assert rst low during PRESENT of a 500 refund.
   - Expected: all outputs zero asynchronously.
   - Next refund 500 issues code 9 with the counter reloaded to INV_INIT.
6. Drain the code-1 notes, then restock+refund_req together in IDLE with refund 1.
   - Expected: code 1 issued and done.

Source files
------------

// File: rtl/payment_pkg.sv
// Shared types and denomination table for the payment path: FSM states,
// note codes and the code-to-value mapping used by the change dispenser.
package payment_pkg;

  localparam int NUM_DENOM = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PRESENT,
    ST_DONE,
    ST_SHORT
  } state_t;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_1    = 4'd1;
  localparam logic [3:0] CODE_2    = 4'd2;
  localparam logic [3:0] CODE_5    = 4'd3;
  localparam logic [3:0] CODE_10   = 4'd4;
  localparam logic [3:0] CODE_20   = 4'd5;
  localparam logic [3:0] CODE_50   = 4'd6;
  localparam logic [3:0] CODE_100  = 4'd7;
  localparam logic [3:0] CODE_200  = 4'd8;
  localparam logic [3:0] CODE_500  = 4'd9;

  // Face value of a note code; unused codes map to 0.
  function automatic logic [9:0] note_value(input logic [3:0] code);
    case (code)
      CODE_1:   note_value = 10'd1;
      CODE_2:   note_value = 10'd2;
      CODE_5:   note_value = 10'd5;
      CODE_10:  note_value = 10'd10;
      CODE_20:  note_value = 10'd20;
      CODE_50:  note_value = 10'd50;
      CODE_100: note_value = 10'd100;
      CODE_200: note_value = 10'd200;
      CODE_500: note_value = 10'd500;
      default:  note_value = 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/note_selector.sv
// Combinational greedy pick: the largest stocked note not exceeding the
// amount still owed.
module note_selector
  import payment_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic [AMT_W-1:0]     remaining,
  input  logic [NUM_DENOM-1:0] avail,
  output logic [3:0]           code,
  output logic                 found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path can hold
    // a previous value, which would otherwise infer a latch.
    code  = CODE_NONE;
    found = 1'b0;
    // Ascending scan, so the last hit is the highest qualifying code.
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (avail[i] && (AMT_W'(note_value(4'(i + 1))) <= remaining)) begin
        code  = 4'(i + 1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a refund amount one note at a time over a valid/ack handshake,
// tracking per-denomination stock and reporting completion or shortfall.
module change_dispenser
  import payment_pkg::*;
#(
  parameter int AMT_W    = 16,
  parameter int CNT_W    = 8,
  parameter int INV_INIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refund_req,
  input  logic [AMT_W-1:0] refund_amt,
  input  logic             restock,
  input  logic             note_ack,
  output logic             note_valid,
  output logic [3:0]       note_code,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] dispensed
);

  state_t                 state;
  logic [CNT_W-1:0]       inv [NUM_DENOM];
  logic [NUM_DENOM-1:0]   avail;
  logic [3:0]             sel_code;
  logic                   sel_found;
  logic [AMT_W-1:0]       cur_val;

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_DENOM; i++) avail[i] = (inv[i] != '0);
  end

  assign cur_val = AMT_W'(note_value(note_code));
  assign busy    = (state != ST_IDLE);

  note_selector #(.AMT_W(AMT_W)) u_sel (
    .remaining (remaining),
    .avail     (avail),
    .code      (sel_code),
    .found     (sel_found)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every read in this block sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      note_valid <= 1'b0;
      note_code  <= CODE_NONE;
      done       <= 1'b0;
      short      <= 1'b0;
      remaining  <= '0;
      dispensed  <= '0;
      // NOTE: the stock counters are a small register array, not a RAM, and
      // must come up full, so they are reset like any other flop.
      for (int i = 0; i < NUM_DENOM; i++) inv[i] <= CNT_W'(INV_INIT);
    end else begin
      done  <= 1'b0;
      short <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (restock)
            for (int i = 0; i < NUM_DENOM; i++) inv[i] <= CNT_W'(INV_INIT);
          if (refund_req) begin
            remaining <= refund_amt;
            dispensed <= '0;
            state     <= (refund_amt == '0) ? ST_DONE : ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (sel_found) begin
            note_code  <= sel_code;
            note_valid <= 1'b1;
            state      <= ST_PRESENT;
          end else if (remaining == '0) begin
            state <= ST_DONE;
          end else begin
            state <= ST_SHORT;
          end
        end
        ST_PRESENT: begin
          if (note_ack) begin
            remaining  <= remaining - cur_val;
            dispensed  <= dispensed + cur_val;
            for (int i = 0; i < NUM_DENOM; i++)
              if (note_code == 4'(i + 1)) inv[i] <= inv[i] - CNT_W'(1);
            note_valid <= 1'b0;
            note_code  <= CODE_NONE;
            state      <= ST_SELECT;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_SHORT: begin
          short <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
